// File: rtl/mem_byte_lane_ctrl_if.sv
// ----------------------------------------------------------------------------
// mem_byte_lane_ctrl_if
//
// CPU-side load/store bus of mem_byte_lane_ctrl.
//   master modport : the CPU (drives the request, receives busy/ack/data)
//   slave modport  : the lane controller
//
// Signals:
//   mem_enable     request strobe, sampled only while the controller is idle
//   mem_write      1 = store, 0 = load
//   mem_width      0 = byte, 1 = half, 2 = word, 3 = reserved (word)
//   mem_sign_ext   loads only: 1 = sign-extend, 0 = zero-extend
//   mem_addr       byte address
//   mem_wdata      store data, right-justified
//   mem_busy       request in flight
//   mem_ack        one-cycle completion pulse
//   mem_rdata      aligned, extended load data, valid with mem_ack
//   mem_misaligned pulses with mem_ack on a misaligned access
// ----------------------------------------------------------------------------
interface mem_byte_lane_ctrl_if #(
    parameter int unsigned ADDR_WIDTH = 16
) ();

    logic                  mem_enable;
    logic                  mem_write;
    logic [1:0]            mem_width;
    logic                  mem_sign_ext;
    logic [ADDR_WIDTH+1:0] mem_addr;
    logic [31:0]           mem_wdata;
    logic                  mem_busy;
    logic                  mem_ack;
    logic [31:0]           mem_rdata;
    logic                  mem_misaligned;

    modport master (
        output mem_enable,
        output mem_write,
        output mem_width,
        output mem_sign_ext,
        output mem_addr,
        output mem_wdata,
        input  mem_busy,
        input  mem_ack,
        input  mem_rdata,
        input  mem_misaligned
    );

    modport slave (
        input  mem_enable,
        input  mem_write,
        input  mem_width,
        input  mem_sign_ext,
        input  mem_addr,
        input  mem_wdata,
        output mem_busy,
        output mem_ack,
        output mem_rdata,
        output mem_misaligned
    );

endinterface

// File: rtl/mem_byte_lane_ctrl.sv
// ----------------------------------------------------------------------------
// mem_byte_lane_ctrl
//
// Sole driver of four 8-bit single-port RAM lanes (lane k holds byte k of each
// 32-bit word). Turns byte/half/word CPU loads and stores into a shared lane
// word address, replicated lane write data and per-lane write strobes, then
// realigns and sign/zero-extends the read data and returns a one-shot ack.
//
// Optional feature macro: MEM_MISALIGN_CHECK_EN
//   defined   : misaligned half/word accesses write nothing and complete with
//               mem_misaligned = 1 and mem_rdata = 0
//   undefined : mem_misaligned is tied low; half accesses ignore addr[0] and
//               word accesses ignore addr[1:0]
//
// Ports:
//   clk        system clock, all state on the rising edge
//   reset_n    asynchronous active-low reset
//   cpu        CPU load/store bus (mem_byte_lane_ctrl_if.slave)
//   lane_addr  word address shared by all lanes
//   lane_din   lane k write data on lane_din[8k+7:8k]
//   lane_we    per-lane write enable
//   lane_dout  lane k read data on lane_dout[8k+7:8k]
// ----------------------------------------------------------------------------
module mem_byte_lane_ctrl #(
    parameter int unsigned ADDR_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    mem_byte_lane_ctrl_if.slave    cpu,
    output logic [ADDR_WIDTH-1:0]  lane_addr,
    output logic [31:0]            lane_din,
    output logic [3:0]             lane_we,
    input  logic [31:0]            lane_dout
);

    localparam logic [1:0] WidthByte = 2'd0;
    localparam logic [1:0] WidthHalf = 2'd1;
    localparam logic [1:0] WidthWord = 2'd2;

    // StRdAddr: the lanes register the address at the accept edge and present
    // data one cycle after that, so the load result is captured leaving StRdWait.
    typedef enum logic [1:0] {
        StIdle,
        StWrDone,
        StRdAddr,
        StRdWait
    } state_e;

    state_e      state_q, state_d;
    logic        ready_q, ready_d;
    logic        busy_q, busy_d;
    logic        ack_q, ack_d;
    logic        mis_out_q, mis_out_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  off_q, off_d;
    logic [1:0]  width_q, width_d;
    logic        sext_q, sext_d;
    logic        mis_q, mis_d;

    logic [1:0]  width_eff;
    logic [1:0]  addr_lo;
    logic [1:0]  offset;
    logic        misaligned;
    logic [3:0]  byte_mask;
    logic        accept;
    logic [31:0] shifted;
    logic [31:0] load_data;

    // ------------------------------------------------------------------------
    // Request decode and combinational lane drive
    // ------------------------------------------------------------------------
    always_comb begin
        width_eff = (cpu.mem_width == 2'd3) ? WidthWord : cpu.mem_width;
        addr_lo   = cpu.mem_addr[1:0];

`ifdef MEM_MISALIGN_CHECK_EN
        misaligned = ((width_eff == WidthHalf) && addr_lo[0]) ||
                     ((width_eff == WidthWord) && (addr_lo != 2'b00));
        offset     = addr_lo;
`else
        misaligned = 1'b0;
        // Force natural alignment by dropping the low address bits.
        case (width_eff)
            WidthByte: offset = addr_lo;
            WidthHalf: offset = {addr_lo[1], 1'b0};
            default:   offset = 2'b00;
        endcase
`endif

        case (width_eff)
            WidthByte: byte_mask = 4'b0001 << offset;
            WidthHalf: byte_mask = offset[1] ? 4'b1100 : 4'b0011;
            default:   byte_mask = 4'b1111;
        endcase

        case (width_eff)
            WidthByte: lane_din = {4{cpu.mem_wdata[7:0]}};
            WidthHalf: lane_din = {2{cpu.mem_wdata[15:0]}};
            default:   lane_din = cpu.mem_wdata;
        endcase

        // ready_q keeps the lanes write-free through the first edge after reset.
        accept    = cpu.mem_enable && ready_q && (state_q == StIdle);
        lane_we   = (accept && cpu.mem_write && !misaligned) ? byte_mask : 4'b0000;
        lane_addr = cpu.mem_addr[ADDR_WIDTH+1:2];
    end

    // ------------------------------------------------------------------------
    // Load realignment from the latched access attributes
    // ------------------------------------------------------------------------
    always_comb begin
        shifted = lane_dout >> {off_q, 3'b000};
        case (width_q)
            WidthByte: load_data = {{24{sext_q & shifted[7]}}, shifted[7:0]};
            WidthHalf: load_data = {{16{sext_q & shifted[15]}}, shifted[15:0]};
            default:   load_data = shifted;
        endcase
    end

    // ------------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        ready_d   = 1'b1;
        ack_d     = 1'b0;
        mis_out_d = 1'b0;
        rdata_d   = rdata_q;
        off_d     = off_q;
        width_d   = width_q;
        sext_d    = sext_q;
        mis_d     = mis_q;

        case (state_q)
            StIdle: begin
                if (accept) begin
                    off_d   = offset;
                    width_d = width_eff;
                    sext_d  = cpu.mem_sign_ext;
                    mis_d   = misaligned;
                    // Misaligned loads never touch the lanes, so they take the
                    // short store path.
                    state_d = (cpu.mem_write || misaligned) ? StWrDone : StRdAddr;
                end
            end
            StWrDone: begin
                state_d   = StIdle;
                ack_d     = 1'b1;
                mis_out_d = mis_q;
                if (mis_q) begin
                    rdata_d = '0;
                end
            end
            StRdAddr: begin
                state_d = StRdWait;
            end
            StRdWait: begin
                state_d = StIdle;
                ack_d   = 1'b1;
                rdata_d = load_data;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    // ------------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            ack_q     <= 1'b0;
            mis_out_q <= 1'b0;
            rdata_q   <= '0;
            off_q     <= 2'b00;
            width_q   <= WidthByte;
            sext_q    <= 1'b0;
            mis_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            ack_q     <= ack_d;
            mis_out_q <= mis_out_d;
            rdata_q   <= rdata_d;
            off_q     <= off_d;
            width_q   <= width_d;
            sext_q    <= sext_d;
            mis_q     <= mis_d;
        end
    end

    assign cpu.mem_busy       = busy_q;
    assign cpu.mem_ack        = ack_q;
    assign cpu.mem_rdata      = rdata_q;
    assign cpu.mem_misaligned = mis_out_q;

endmodule
